datapath: RTL and testbench
===========================

DATAPATH -- requirements
Module: datapath

Interface
REQ-001 clk  input  1  single system clock; all state updates on rising edge.
REQ-002 clr  input  1  reset, synchronous, active-high.
REQ-003 enable  input  32  binary-encoded destination-register code; only bits [4:0] decoded; bits [31:5] ignored.
REQ-004 busSelect  input  32  binary-encoded bus-source code; only bits [4:0] decoded; bits [31:5] ignored.
REQ-005 inPort  input  32  external input-port data, bus source code 22.
REQ-006 MDataIn  input  32  memory read data into MDR.
REQ-007 MD_Read  input  1  MDR input mux select: 1 = MDataIn, 0 = bus.
REQ-008 Control_Signals  input  4  ALU opcode.
REQ-009 busMuxOut  output  32  current bus value, combinational.

Function
REQ-010 Codes shared by enable and busSelect: 0 none; 1-15 R1-R15; 16 HI; 17 LO; 18 ZHigh; 19 ZLow; 20 PC; 21 MDR; 22 InPort; 23 IR; 24 Z; 25 MAR; 26 IncPC; 27 Y; 28-31 none.
REQ-011 busMuxOut = selected source; code 0 or any non-readable code (23 IR, 24, 25, 26, 27, 28-31) drives 32'h0.
REQ-012 R0 does not exist as storage; no code writes it.
REQ-013 Exactly one destination loads per clock: the one named by enable[4:0].
REQ-014 Rn, HI, LO, PC, IR, MAR, Y load busMuxOut when their code is on enable.
REQ-015 MDR (code 21) loads MD_Read ? MDataIn : busMuxOut.
REQ-016 InPort register loads inPort every clock; no enable needed.
REQ-017 Code 24 loads 64-bit Z with the ALU result; ZHigh = Z[63:32], ZLow = Z[31:0].
REQ-018 Code 26 sets PC <= PC + 1, wraps 32'hFFFFFFFF -> 0; bus ignored.
REQ-019 ALU operands: A = Y, B = busMuxOut; shift/rotate amount = B[4:0].
REQ-020 Opcodes: 0 ADD, 1 SUB (A-B), 2 AND, 3 OR, 4 SHR logical, 5 SHRA arithmetic, 6 SHL, 7 ROR, 8 NEG (-B), 9 NOT (~B), 10 ROL, 11 MUL signed, 12 DIV signed, 13-15 result 0.
REQ-021 Ops 0-10: 32-bit result in Z[31:0]; Z[63:32] zero, except ADD carry-out in Z[32].
REQ-022 MUL: Z = full 64-bit signed product.
REQ-023 DIV: Z[31:0] = quotient, Z[63:32] = remainder; B = 0 yields Z = 0.
REQ-024 Rotate by 0 returns A unchanged; amounts use only 5 bits (32 behaves as 0).
REQ-025 Single-cycle ALU; Z valid on the edge that samples enable = 24.

Reset
REQ-026 clr = 1 at a rising edge zeroes all registers (R1-R15, HI, LO, Z, PC, MDR, InPort, IR, MAR, Y), overriding any enable that cycle.
REQ-027 busMuxOut follows registers after reset; with busSelect = 0 it is 0.
REQ-028 Reset mid-sequence discards partial operation; no state survives.

Configuration
REQ-029 Macro DATAPATH_MULDIV_EN defined: opcodes 11 and 12 implemented per REQ-022/023.
REQ-030 Macro undefined: no multiplier/divider logic; opcodes 11 and 12 give Z = 0.

Structure
REQ-031 Package datapath_pkg holds register-code constants (REQ-010) and ALU opcode constants (REQ-020).
REQ-032 One sub-module, datapath_alu: combinational, inputs A, B, opcode; 64-bit result output.

Verification
REQ-033 ROL: load R3 = 1 and R5 = 4 via MDR (MD_Read = 1, enable = 21; then busSelect = 21, enable = 3/5); Y <- R3; busSelect = 5, op 10, enable = 24; busSelect = 19, enable = 1 -> R1 = 32'h00000010.
REQ-034 ROL wrap: Y = 32'h80000001, B = 4 -> ZLow = 32'h00000018; B = 0 -> ZLow = 32'h80000001.
REQ-035 IncPC: PC = 32'hFFFFFFFF, enable = 26 -> PC = 0; enable = 0 for 3 cycles -> no register changes.
REQ-036 MDR mux: MD_Read = 0, busSelect = 22 with inPort = 32'hA5A5A5A5, enable = 21 -> MDR = 32'hA5A5A5A5.
REQ-037 MUL with DATAPATH_MULDIV_EN: Y = -2, B = 3 -> Z = 64'hFFFFFFFFFFFFFFFA; without the macro -> Z = 0.
REQ-038 Reset: assert clr during a Z load -> all registers 0 next edge; busSelect = 19 -> busMuxOut = 0.

Source files
------------

// File: rtl/datapath_pkg.sv
// rtl/datapath_pkg.sv - register codes and ALU opcodes shared by the datapath
package datapath_pkg;

    // Register codes shared by the enable and busSelect inputs
    localparam logic [4:0] CODE_NONE   = 5'd0;
    localparam logic [4:0] CODE_R1     = 5'd1;
    localparam logic [4:0] CODE_R15    = 5'd15;
    localparam logic [4:0] CODE_HI     = 5'd16;
    localparam logic [4:0] CODE_LO     = 5'd17;
    localparam logic [4:0] CODE_ZHIGH  = 5'd18;
    localparam logic [4:0] CODE_ZLOW   = 5'd19;
    localparam logic [4:0] CODE_PC     = 5'd20;
    localparam logic [4:0] CODE_MDR    = 5'd21;
    localparam logic [4:0] CODE_INPORT = 5'd22;
    localparam logic [4:0] CODE_IR     = 5'd23;
    localparam logic [4:0] CODE_Z      = 5'd24;
    localparam logic [4:0] CODE_MAR    = 5'd25;
    localparam logic [4:0] CODE_INCPC  = 5'd26;
    localparam logic [4:0] CODE_Y      = 5'd27;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_SHR  = 4'd4;
    localparam logic [3:0] OP_SHRA = 4'd5;
    localparam logic [3:0] OP_SHL  = 4'd6;
    localparam logic [3:0] OP_ROR  = 4'd7;
    localparam logic [3:0] OP_NEG  = 4'd8;
    localparam logic [3:0] OP_NOT  = 4'd9;
    localparam logic [3:0] OP_ROL  = 4'd10;
    localparam logic [3:0] OP_MUL  = 4'd11;
    localparam logic [3:0] OP_DIV  = 4'd12;

endpackage

// File: rtl/datapath_alu.sv
// rtl/datapath_alu.sv - combinational ALU, 64-bit result; MUL/DIV only with DATAPATH_MULDIV_EN
module datapath_alu
    import datapath_pkg::*;
(
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic [3:0]  op_i,
    output logic [63:0] result_o
);

    logic [4:0]  amt;
    logic [32:0] sum;
    logic [63:0] dbl;
    logic [63:0] ror_full;
    logic [63:0] rol_full;

    assign amt = b_i[4:0];
    assign sum = {1'b0, a_i} + {1'b0, b_i};
    // Rotates fall out of shifting A concatenated with itself
    assign dbl      = {a_i, a_i};
    assign ror_full = dbl >> amt;
    assign rol_full = dbl << amt;

`ifdef DATAPATH_MULDIV_EN
    logic signed [63:0] prod;
    logic signed [31:0] quot;
    logic signed [31:0] rem;

    assign prod = $signed({{32{a_i[31]}}, a_i}) * $signed({{32{b_i[31]}}, b_i});
    assign quot = (b_i == 32'd0) ? 32'sd0 : $signed(a_i) / $signed(b_i);
    assign rem  = (b_i == 32'd0) ? 32'sd0 : $signed(a_i) % $signed(b_i);
`endif

    always_comb begin
        result_o = '0;
        case (op_i)
            OP_ADD:  result_o = {31'd0, sum};
            OP_SUB:  result_o = {32'd0, a_i - b_i};
            OP_AND:  result_o = {32'd0, a_i & b_i};
            OP_OR:   result_o = {32'd0, a_i | b_i};
            OP_SHR:  result_o = {32'd0, a_i >> amt};
            OP_SHRA: result_o = {32'd0, $signed(a_i) >>> amt};
            OP_SHL:  result_o = {32'd0, a_i << amt};
            OP_ROR:  result_o = {32'd0, ror_full[31:0]};
            OP_NEG:  result_o = {32'd0, 32'd0 - b_i};
            OP_NOT:  result_o = {32'd0, ~b_i};
            OP_ROL:  result_o = {32'd0, rol_full[63:32]};
`ifdef DATAPATH_MULDIV_EN
            OP_MUL:  result_o = prod;
            OP_DIV:  result_o = {rem, quot};
`endif
            default: result_o = '0;
        endcase
    end

endmodule

// File: rtl/datapath.sv
// rtl/datapath.sv - register file, bus mux and Z/PC/MDR datapath top (MUL/DIV via DATAPATH_MULDIV_EN)
module datapath
    import datapath_pkg::*;
(
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] enable,
    input  logic [31:0] busSelect,
    input  logic [31:0] inPort,
    input  logic [31:0] MDataIn,
    input  logic        MD_Read,
    input  logic [3:0]  Control_Signals,
    output logic [31:0] busMuxOut
);

    logic [31:0] r_q [1:15];
    logic [31:0] r_d [1:15];
    logic [31:0] hi_q, hi_d, lo_q, lo_d, pc_q, pc_d, mdr_q, mdr_d;
    logic [31:0] inport_q, inport_d, ir_q, ir_d, mar_q, mar_d, y_q, y_d;
    logic [63:0] z_q, z_d;
    logic [63:0] alu_result;
    logic [4:0]  src;
    logic [4:0]  dst;
    logic        sel_unused;

    assign src = busSelect[4:0];
    assign dst = enable[4:0];
    // IR and MAR feed nothing inside this block; upper code bits are don't-care
    assign sel_unused = ^{enable[31:5], busSelect[31:5], ir_q, mar_q};

    always_comb begin
        busMuxOut = '0;
        case (src)
            CODE_HI:     busMuxOut = hi_q;
            CODE_LO:     busMuxOut = lo_q;
            CODE_ZHIGH:  busMuxOut = z_q[63:32];
            CODE_ZLOW:   busMuxOut = z_q[31:0];
            CODE_PC:     busMuxOut = pc_q;
            CODE_MDR:    busMuxOut = mdr_q;
            CODE_INPORT: busMuxOut = inport_q;
            default: begin
                if (src inside {[CODE_R1:CODE_R15]}) busMuxOut = r_q[src[3:0]];
            end
        endcase
    end

    datapath_alu u_alu (
        .a_i      (y_q),
        .b_i      (busMuxOut),
        .op_i     (Control_Signals),
        .result_o (alu_result)
    );

    always_comb begin
        for (int i = 1; i <= 15; i++) r_d[i] = r_q[i];
        hi_d     = hi_q;
        lo_d     = lo_q;
        pc_d     = pc_q;
        mdr_d    = mdr_q;
        ir_d     = ir_q;
        mar_d    = mar_q;
        y_d      = y_q;
        z_d      = z_q;
        inport_d = inPort;
        case (dst)
            CODE_HI:    hi_d  = busMuxOut;
            CODE_LO:    lo_d  = busMuxOut;
            CODE_PC:    pc_d  = busMuxOut;
            CODE_MDR:   mdr_d = MD_Read ? MDataIn : busMuxOut;
            CODE_IR:    ir_d  = busMuxOut;
            CODE_Z:     z_d   = alu_result;
            CODE_MAR:   mar_d = busMuxOut;
            CODE_INCPC: pc_d  = pc_q + 32'd1;
            CODE_Y:     y_d   = busMuxOut;
            default: begin
                if (dst inside {[CODE_R1:CODE_R15]}) r_d[dst[3:0]] = busMuxOut;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 1; i <= 15; i++) r_q[i] <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            pc_q     <= '0;
            mdr_q    <= '0;
            inport_q <= '0;
            ir_q     <= '0;
            mar_q    <= '0;
            y_q      <= '0;
            z_q      <= '0;
        end else begin
            r_q      <= r_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            pc_q     <= pc_d;
            mdr_q    <= mdr_d;
            inport_q <= inport_d;
            ir_q     <= ir_d;
            mar_q    <= mar_d;
            y_q      <= y_d;
            z_q      <= z_d;
        end
    end

endmodule

// File: tb/tb_datapath.sv
// tb/tb_datapath.sv - scoreboard bench for datapath; MUL/DIV expectations follow DATAPATH_MULDIV_EN
module tb_datapath;

    logic        clk = 1'b0;
    logic        clr;
    logic [31:0] enable;
    logic [31:0] busSelect;
    logic [31:0] inPort;
    logic [31:0] MDataIn;
    logic        MD_Read;
    logic [3:0]  Control_Signals;
    logic [31:0] busMuxOut;

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_q [$];
    string       tag_q [$];

    always #20 clk = ~clk;

    datapath dut (
        .clk             (clk),
        .clr             (clr),
        .enable          (enable),
        .busSelect       (busSelect),
        .inPort          (inPort),
        .MDataIn         (MDataIn),
        .MD_Read         (MD_Read),
        .Control_Signals (Control_Signals),
        .busMuxOut       (busMuxOut)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input string tag, input logic [31:0] val);
        exp_q.push_back(val);
        tag_q.push_back(tag);
    endtask

    // Pops the oldest expectation and compares it with the bus showing register 'sel'
    task automatic observe(input logic [4:0] sel);
        logic [31:0] e;
        string       t;
        busSelect = {27'd0, sel};
        enable    = 32'd0;
        #1;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_empty: got none expected entry");
        end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            check_eq(t, busMuxOut, e);
        end
    endtask

    task automatic drive(input logic [4:0] sel, input logic [4:0] dst, input logic [3:0] op = 4'd0);
        busSelect       = {27'd0, sel};
        enable          = {27'd0, dst};
        MD_Read         = 1'b0;
        Control_Signals = op;
        @(negedge clk);
        enable = 32'd0;
    endtask

    task automatic set_reg(input logic [4:0] dst, input logic [31:0] val);
        MD_Read = 1'b1;
        MDataIn = val;
        enable  = 32'd21;
        @(negedge clk);
        drive(5'd21, dst);
    endtask

    task automatic alu_z(input string tag, input logic [31:0] y, input logic [31:0] b,
                         input logic [3:0] op, input logic [31:0] zhi, input logic [31:0] zlo);
        push_exp({tag, "_zlo"}, zlo);
        push_exp({tag, "_zhi"}, zhi);
        set_reg(5'd27, y);
        set_reg(5'd2, b);
        drive(5'd2, 5'd24, op);
        observe(5'd19);
        observe(5'd18);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clr = 1'b1; enable = '0; busSelect = '0; inPort = '0;
        MDataIn = '0; MD_Read = 1'b0; Control_Signals = '0;
        @(negedge clk);
        @(negedge clk);
        clr = 1'b0;

        foreach (exp_q[i]) exp_q.delete();
        push_exp("rst_bus0", 32'd0);   observe(5'd0);
        push_exp("rst_r1", 32'd0);     observe(5'd1);
        push_exp("rst_r15", 32'd0);    observe(5'd15);
        push_exp("rst_hi", 32'd0);     observe(5'd16);
        push_exp("rst_lo", 32'd0);     observe(5'd17);
        push_exp("rst_zhi", 32'd0);    observe(5'd18);
        push_exp("rst_zlo", 32'd0);    observe(5'd19);
        push_exp("rst_pc", 32'd0);     observe(5'd20);
        push_exp("rst_mdr", 32'd0);    observe(5'd21);

        // ROL sequence through MDR loads
        push_exp("rol_seq_r1", 32'h0000_0010);
        set_reg(5'd3, 32'd1);
        set_reg(5'd5, 32'd4);
        drive(5'd3, 5'd27);
        drive(5'd5, 5'd24, 4'd10);
        drive(5'd19, 5'd1);
        observe(5'd1);

        alu_z("rol_wrap",  32'h8000_0001, 32'd4,  4'd10, 32'd0, 32'h0000_0018);
        alu_z("rol_zero",  32'h8000_0001, 32'd0,  4'd10, 32'd0, 32'h8000_0001);
        alu_z("rol_32",    32'h8000_0001, 32'd32, 4'd10, 32'd0, 32'h8000_0001);
        alu_z("ror",       32'h8000_0001, 32'd4,  4'd7,  32'd0, 32'h1800_0000);
        alu_z("add_carry", 32'hFFFF_FFFF, 32'd1,  4'd0,  32'd1, 32'd0);
        alu_z("add",       32'd100,       32'd23, 4'd0,  32'd0, 32'd123);
        alu_z("sub",       32'd5,         32'd7,  4'd1,  32'd0, 32'hFFFF_FFFE);
        alu_z("and",       32'hF0F0_00FF, 32'h0FF0_0F0F, 4'd2, 32'd0, 32'h00F0_000F);
        alu_z("or",        32'hF0F0_00FF, 32'h0FF0_0F0F, 4'd3, 32'd0, 32'hFFF0_0FFF);
        alu_z("shr",       32'h8000_0000, 32'd4,  4'd4,  32'd0, 32'h0800_0000);
        alu_z("shra",      32'h8000_0000, 32'd4,  4'd5,  32'd0, 32'hF800_0000);
        alu_z("shl_amt5",  32'd1,         32'd36, 4'd6,  32'd0, 32'h0000_0010);
        alu_z("neg",       32'd0,         32'd3,  4'd8,  32'd0, 32'hFFFF_FFFD);
        alu_z("not",       32'd0,         32'h0F0F_0F0F, 4'd9, 32'd0, 32'hF0F0_F0F0);
        alu_z("op13",      32'd5,         32'd3,  4'd13, 32'd0, 32'd0);
`ifdef DATAPATH_MULDIV_EN
        alu_z("mul",       32'hFFFF_FFFE, 32'd3,  4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        alu_z("div",       32'hFFFF_FFF9, 32'd2,  4'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
`else
        alu_z("mul",       32'hFFFF_FFFE, 32'd3,  4'd11, 32'd0, 32'd0);
        alu_z("div",       32'hFFFF_FFF9, 32'd2,  4'd12, 32'd0, 32'd0);
`endif
        alu_z("div0",      32'd77,        32'd0,  4'd12, 32'd0, 32'd0);

        push_exp("hi_load", 32'h1234_5678);
        set_reg(5'd16, 32'h1234_5678);
        observe(5'd16);
        push_exp("lo_load", 32'h8765_4321);
        set_reg(5'd17, 32'h8765_4321);
        observe(5'd17);
        push_exp("ir_unreadable", 32'd0);
        set_reg(5'd23, 32'hDEAD_BEEF);
        observe(5'd23);
        push_exp("y_unreadable", 32'd0);
        observe(5'd27);

        // IncPC wrap, then idle cycles must leave state untouched
        push_exp("incpc_wrap", 32'd0);
        set_reg(5'd20, 32'hFFFF_FFFF);
        drive(5'd0, 5'd26);
        observe(5'd20);
        push_exp("idle_pc", 32'd0);
        push_exp("idle_mdr", 32'hFFFF_FFFF);
        push_exp("idle_hi", 32'h1234_5678);
        for (int i = 0; i < 3; i++) begin
            MD_Read   = 1'b1;
            MDataIn   = $urandom;
            busSelect = {27'd0, 5'(i + 16)};
            enable    = 32'd0;
            @(negedge clk);
        end
        observe(5'd20);
        observe(5'd21);
        observe(5'd16);

        push_exp("mdr_from_bus", 32'hA5A5_A5A5);
        inPort = 32'hA5A5_A5A5;
        @(negedge clk);
        MDataIn   = 32'h5A5A_5A5A;
        MD_Read   = 1'b0;
        busSelect = 32'd22;
        enable    = 32'd21;
        @(negedge clk);
        observe(5'd21);

        // Reset asserted while a Z load is in flight
        push_exp("clr_zlo", 32'd0);
        push_exp("clr_zhi", 32'd0);
        push_exp("clr_r3", 32'd0);
        push_exp("clr_r5", 32'd0);
        push_exp("clr_hi", 32'd0);
        push_exp("clr_mdr", 32'd0);
        push_exp("clr_inport", 32'd0);
        set_reg(5'd27, 32'd7);
        set_reg(5'd2, 32'd9);
        busSelect       = 32'd2;
        Control_Signals = 4'd0;
        enable          = 32'd24;
        clr             = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        observe(5'd19);
        observe(5'd18);
        observe(5'd3);
        observe(5'd5);
        observe(5'd16);
        observe(5'd21);
        observe(5'd22);
        push_exp("clr_y", 32'd0);
        drive(5'd0, 5'd24, 4'd0);
        observe(5'd19);

        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_leftover: got %0d expected 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
